// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// PC increment and the default bubble instruction.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller
// (master) and the instruction memory (slave).
interface fetch_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int INSN_W = 32
);
    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_ready;
    logic [INSN_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl_ifid_pipe_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, and a cycle
// that is neither held nor loaded turns the stage into a bubble.
module ifid_pipe_reg
    import fetch_ctrl_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter int                INSN_W   = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(NOP_INSN_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              load,
    input  logic [XLEN-1:0]   load_pc,
    input  logic [INSN_W-1:0] load_instr,
    output logic              ifid_valid,
    output logic [XLEN-1:0]   ifid_pc,
    output logic [XLEN-1:0]   ifid_pc4,
    output logic [INSN_W-1:0] ifid_instr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
            ifid_instr <= NOP_INSN;
        end else if (load && !flush) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= load_pc;
            ifid_pc4   <= load_pc + XLEN'(PC_INC);
            ifid_instr <= load_instr;
        end else if (flush || !hold) begin
            // PC fields keep their last value; only validity and the word change
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSN;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues imem requests for the current PC,
// steers the PC register and loads IF/ID, handling load-use stalls and redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter int                INSN_W   = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(NOP_INSN_DEFAULT),
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_result,
    output logic              pc_stall,
    input  logic              hz_stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    fetch_ctrl_if.master      imem,
    output logic              ifid_valid,
    output logic [XLEN-1:0]   ifid_pc,
    output logic [XLEN-1:0]   ifid_pc4,
    output logic [INSN_W-1:0] ifid_instr,
    output logic [CNT_W-1:0]  fetch_stall_cnt
);

    fetch_state_t      state_reg;
    logic [XLEN-1:0]   drop_addr_reg;
    logic [XLEN-1:0]   hold_pc_reg;
    logic [INSN_W-1:0] hold_instr_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic              accept_req;
    logic              accept_hold;
    logic              accept;
    logic [XLEN-1:0]   load_pc;
    logic [INSN_W-1:0] load_instr;

    assign accept_req  = (state_reg == ST_REQ) && imem.imem_ready && !hz_stall && !redirect_valid;
    assign accept_hold = (state_reg == ST_HOLD) && !hz_stall && !redirect_valid;
    assign accept      = accept_req || accept_hold;

    assign load_pc    = accept_hold ? hold_pc_reg    : pc;
    assign load_instr = accept_hold ? hold_instr_reg : imem.imem_rdata;

    assign pc_result = redirect_valid ? redirect_target : pc + XLEN'(PC_INC);
    assign pc_stall  = !(redirect_valid || accept);

    // The request line drops immediately with reset so memory sees the abandon
    assign imem.imem_req  = reset_n && (state_reg != ST_HOLD);
    assign imem.imem_addr = (state_reg == ST_DROP) ? drop_addr_reg : pc;

    assign fetch_stall_cnt = stall_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_REQ;
            drop_addr_reg  <= '0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= NOP_INSN;
            stall_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (redirect_valid) begin
                        // An unanswered request must be drained before refetching
                        if (!imem.imem_ready) begin
                            drop_addr_reg <= pc;
                            state_reg     <= ST_DROP;
                        end
                    end else if (imem.imem_ready && hz_stall) begin
                        hold_pc_reg    <= pc;
                        hold_instr_reg <= imem.imem_rdata;
                        state_reg      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || !hz_stall) begin
                        state_reg <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    // The stale response completes the old request even if
                    // another redirect lands in the same cycle
                    if (imem.imem_ready) begin
                        state_reg <= ST_REQ;
                    end
                end
                default: state_reg <= ST_REQ;
            endcase

            if (pc_stall && !hz_stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    ifid_pipe_reg #(
        .XLEN     (XLEN),
        .INSN_W   (INSN_W),
        .NOP_INSN (NOP_INSN)
    ) u_ifid (
        .clk        (clk),
        .reset_n    (reset_n),
        .hold       (hz_stall),
        .flush      (redirect_valid),
        .load       (accept),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_instr (ifid_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register and an address-derived
// instruction memory (word = addr ^ 32'hDEAD0000).
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] pc_result;
    logic        pc_stall;
    logic        hz_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic [31:0] fetch_stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_ctrl_if #(.XLEN(32), .INSN_W(32)) mif ();

    assign mif.imem_rdata = mif.imem_addr ^ 32'hDEAD_0000;

    always #5 clk = ~clk;

    // PC register partner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      pc <= '0;
        else if (!pc_stall) pc <= pc_result;
    end

    fetch_ctrl #(
        .XLEN     (32),
        .INSN_W   (32),
        .NOP_INSN (32'h0),
        .CNT_W    (32)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc              (pc),
        .pc_result       (pc_result),
        .pc_stall        (pc_stall),
        .hz_stall        (hz_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (mif),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_pc4        (ifid_pc4),
        .ifid_instr      (ifid_instr),
        .fetch_stall_cnt (fetch_stall_cnt)
    );

    task automatic drive(input logic rdy, input logic hz, input logic red, input logic [31:0] tgt);
        mif.imem_ready  = rdy;
        hz_stall        = hz;
        redirect_valid  = red;
        redirect_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_accepts(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tick();
            $display("[TB] accept ifid_pc=%h instr=%h", ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        tests_run++; if (mif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", mif.imem_req); end
        tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
        tests_run++; if (ifid_pc4 !== 32'h0) begin tests_failed++; $display("FAIL reset_pc4: got %h expected 0", ifid_pc4); end
        tests_run++; if (ifid_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h expected 0", ifid_instr); end
        tests_run++; if (fetch_stall_cnt !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", fetch_stall_cnt); end
        tick();
        reset_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            tests_run++; if (pc_stall !== 1'b0) begin tests_failed++; $display("FAIL stream_stall[%0d]: got %b expected 0", i, pc_stall); end
            tests_run++; if (mif.imem_addr !== a) begin tests_failed++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, mif.imem_addr, a); end
            tick();
            $display("[TB] stream ifid_pc=%h instr=%h", ifid_pc, ifid_instr);
            tests_run++; if (ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, ifid_valid); end
            tests_run++; if (ifid_pc !== a) begin tests_failed++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, ifid_pc, a); end
            tests_run++; if (ifid_pc4 !== a + 32'd4) begin tests_failed++; $display("FAIL stream_pc4[%0d]: got %h expected %h", i, ifid_pc4, a + 32'd4); end
            tests_run++; if (ifid_instr !== (32'hDEAD_0000 | a)) begin tests_failed++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, ifid_instr, 32'hDEAD_0000 | a); end
        end
        tests_run++; if (fetch_stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL stream_cnt: got %0d expected 0", fetch_stall_cnt); end
    endtask

    task automatic test_mem_wait();
        run_accepts(1);  // pc now 0x10
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL wait_stall[%0d]: got %b expected 1", i, pc_stall); end
            tests_run++; if (mif.imem_addr !== 32'h10) begin tests_failed++; $display("FAIL wait_addr[%0d]: got %h expected 10", i, mif.imem_addr); end
            tick();
            $display("[TB] wait cycle %0d ifid_valid=%b", i, ifid_valid);
            tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_bubble[%0d]: got %b expected 0", i, ifid_valid); end
            tests_run++; if (ifid_instr !== 32'h0) begin tests_failed++; $display("FAIL wait_nop[%0d]: got %h expected 0", i, ifid_instr); end
        end
        tests_run++; if (fetch_stall_cnt !== 32'd3) begin tests_failed++; $display("FAIL wait_cnt: got %0d expected 3", fetch_stall_cnt); end
        run_accepts(1);
        tests_run++; if (ifid_pc !== 32'h10) begin tests_failed++; $display("FAIL wait_resume_pc: got %h expected 10", ifid_pc); end
        run_accepts(3);  // pc now 0x20
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL hold_cap_stall: got %b expected 1", pc_stall); end
        tick();
        $display("[TB] hold capture ifid_pc=%h", ifid_pc);
        tests_run++; if (ifid_pc !== 32'h1C) begin tests_failed++; $display("FAIL hold_cap_ifid: got %h expected 1c", ifid_pc); end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        tests_run++; if (mif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL hold_req: got %b expected 0", mif.imem_req); end
        tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL hold_stall: got %b expected 1", pc_stall); end
        tick();
        tests_run++; if (ifid_instr !== 32'hDEAD_001C) begin tests_failed++; $display("FAIL hold_keep_instr: got %h expected dead001c", ifid_instr); end
        tests_run++; if (ifid_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_keep_valid: got %b expected 1", ifid_valid); end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        tests_run++; if (pc_stall !== 1'b0) begin tests_failed++; $display("FAIL hold_rel_stall: got %b expected 0", pc_stall); end
        tick();
        $display("[TB] hold release ifid_pc=%h pc=%h", ifid_pc, pc);
        tests_run++; if (ifid_pc !== 32'h20) begin tests_failed++; $display("FAIL hold_rel_pc: got %h expected 20", ifid_pc); end
        tests_run++; if (ifid_instr !== 32'hDEAD_0020) begin tests_failed++; $display("FAIL hold_rel_instr: got %h expected dead0020", ifid_instr); end
        tests_run++; if (pc !== 32'h24) begin tests_failed++; $display("FAIL hold_rel_next: got %h expected 24", pc); end
        tests_run++; if (fetch_stall_cnt !== 32'd3) begin tests_failed++; $display("FAIL hold_cnt: got %0d expected 3", fetch_stall_cnt); end
    endtask

    task automatic test_redirect_drop();
        run_accepts(3);  // pc now 0x30
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        #1;
        tests_run++; if (pc_result !== 32'h100) begin tests_failed++; $display("FAIL drop_result: got %h expected 100", pc_result); end
        tests_run++; if (pc_stall !== 1'b0) begin tests_failed++; $display("FAIL drop_redir_stall: got %b expected 0", pc_stall); end
        tick();
        $display("[TB] redirect to %h", pc);
        tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_flush: got %b expected 0", ifid_valid); end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        tests_run++; if (mif.imem_addr !== 32'h30) begin tests_failed++; $display("FAIL drop_addr0: got %h expected 30", mif.imem_addr); end
        tests_run++; if (mif.imem_req !== 1'b1) begin tests_failed++; $display("FAIL drop_req: got %b expected 1", mif.imem_req); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        tests_run++; if (mif.imem_addr !== 32'h30) begin tests_failed++; $display("FAIL drop_addr1: got %h expected 30", mif.imem_addr); end
        tests_run++; if (pc_stall !== 1'b1) begin tests_failed++; $display("FAIL drop_stall: got %b expected 1", pc_stall); end
        tick();
        $display("[TB] stale response discarded ifid_valid=%b", ifid_valid);
        tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_discard: got %b expected 0", ifid_valid); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        tests_run++; if (mif.imem_addr !== 32'h100) begin tests_failed++; $display("FAIL drop_newaddr: got %h expected 100", mif.imem_addr); end
        tick();
        tests_run++; if (ifid_pc !== 32'h100) begin tests_failed++; $display("FAIL drop_newpc: got %h expected 100", ifid_pc); end
        tests_run++; if (ifid_instr !== 32'hDEAD_0100) begin tests_failed++; $display("FAIL drop_newinstr: got %h expected dead0100", ifid_instr); end
        tests_run++; if (fetch_stall_cnt !== 32'd5) begin tests_failed++; $display("FAIL drop_cnt: got %0d expected 5", fetch_stall_cnt); end
    endtask

    task automatic test_redirect_hz();
        drive(1'b1, 1'b1, 1'b1, 32'h200);
        #1;
        tests_run++; if (pc_stall !== 1'b0) begin tests_failed++; $display("FAIL rhz_stall: got %b expected 0", pc_stall); end
        tick();
        $display("[TB] redirect+hz pc=%h ifid_valid=%b", pc, ifid_valid);
        tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL rhz_flush: got %b expected 0", ifid_valid); end
        tests_run++; if (pc !== 32'h200) begin tests_failed++; $display("FAIL rhz_pc: got %h expected 200", pc); end
        run_accepts(1);
        tests_run++; if (ifid_pc !== 32'h200) begin tests_failed++; $display("FAIL rhz_next: got %h expected 200", ifid_pc); end
        tests_run++; if (fetch_stall_cnt !== 32'd5) begin tests_failed++; $display("FAIL rhz_cnt: got %0d expected 5", fetch_stall_cnt); end
    endtask

    task automatic test_reset_in_hold();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tests_run++; if (mif.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rh_inhold: got %b expected 0", mif.imem_req); end
        reset_n = 1'b0;
        #1;
        $display("[TB] reset asserted in HOLD");
        tests_run++; if (ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL rh_valid: got %b expected 0", ifid_valid); end
        tests_run++; if (ifid_pc !== 32'h0) begin tests_failed++; $display("FAIL rh_ifidpc: got %h expected 0", ifid_pc); end
        tests_run++; if (fetch_stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL rh_cnt: got %0d expected 0", fetch_stall_cnt); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests_run++; if (mif.imem_req !== 1'b1) begin tests_failed++; $display("FAIL rh_req: got %b expected 1", mif.imem_req); end
        tests_run++; if (mif.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rh_addr: got %h expected 0", mif.imem_addr); end
        tick();
        $display("[TB] restart ifid_pc=%h pc=%h", ifid_pc, pc);
        tests_run++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0) begin tests_failed++; $display("FAIL rh_restart: got valid=%b pc=%h expected valid=1 pc=0", ifid_valid, ifid_pc); end
        tests_run++; if (pc !== 32'h4) begin tests_failed++; $display("FAIL rh_pcnext: got %h expected 4", pc); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_mem_wait();
        test_hold();
        test_redirect_drop();
        test_redirect_hz();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
